chain_pulse_stim: RTL
=====================

CHAIN_PULSE_STIM -- requirements
Module: chain_pulse_stim

Interface
REQ-001 SHALL have parameter CFG_W, default 8: width of the pulse width, gap and count configuration fields.
REQ-002 SHALL have parameter EDGE_W, default 16: width of the returned-edge counter.
REQ-003 SHALL have port clk, input, 1: the single clock; all state SHALL be on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-005 SHALL have port start, input, 1: single-cycle request to launch a pulse train.
REQ-006 SHALL have port pulse_width, input, CFG_W: high time per pulse, in clk cycles.
REQ-007 SHALL have port pulse_gap, input, CFG_W: low time after each pulse, in clk cycles.
REQ-008 SHALL have port pulse_count, input, CFG_W: number of pulses in the train.
REQ-009 SHALL have port myin, output, 1: stimulus driven into the chain input.
REQ-010 SHALL have port mygnd, output, 1: constant 0, the chain's tied side input.
REQ-011 SHALL have port myout, input, 1: chain output; asynchronous to clk.
REQ-012 SHALL have port busy, output, 1: high while a train is in progress.
REQ-013 SHALL have port done, output, 1: one-cycle pulse at train completion.
REQ-014 SHALL have port edge_count, output, EDGE_W: number of myout transitions since the last accepted start.

Function
REQ-015 SHALL use FSM states IDLE, HIGH, LOW and DONE.
REQ-016 In IDLE with start=1, SHALL latch pulse_width, pulse_gap and pulse_count, clear edge_count, and assert busy from the next cycle.
REQ-017 On start with pulse_count=0 or pulse_width=0, SHALL go to DONE with no pulse, so myin stays 0 and done is high the next cycle.
REQ-018 Otherwise, on start SHALL enter HIGH, with myin=1 from the next cycle.
REQ-019 SHALL hold myin=1 in HIGH for exactly the latched width cycles, then enter LOW.
REQ-020 SHALL hold myin=0 in LOW for max(latched gap, 1) cycles, so a zero gap still yields a 1-cycle low.
REQ-021 At the end of LOW, SHALL enter HIGH if pulses remain, otherwise DONE.
REQ-022 DONE SHALL last one cycle with done=1 and busy=0, then return to IDLE.
REQ-023 start SHALL be ignored in HIGH, LOW and DONE; config input changes while busy SHALL have no effect.
REQ-024 myin SHALL be a direct register output (glitch-free); mygnd SHALL be constant 0.
REQ-025 SHALL pass myout through a 2-flop synchronizer, then a third flop for edge detection.
REQ-026 SHALL increment edge_count by 1 on each rising or falling edge of the synchronized myout, in every state.
REQ-027 edge_count SHALL saturate at all-ones.
REQ-028 SHALL let edge_count keep counting after done (late chain edges), until the next accepted start clears it.
REQ-029 If start clears edge_count in the same cycle an edge is detected, the clear SHALL win.
REQ-030 Pulse and cycle counters SHALL be CFG_W bits wide, count down, and never wrap.

Reset
REQ-031 While rst_n=0, SHALL force: state IDLE; myin=0, busy=0, done=0, edge_count=0; synchronizer and edge flops 0; latched config 0.
REQ-032 Reset asserted mid-train SHALL drop myin to 0 immediately (asynchronously), with no done pulse.
REQ-033 After rst_n deasserts, the first start SHALL be accepted on the first clk edge.

Structure
REQ-034 The FSM state enum and the default CFG_W and EDGE_W SHALL live in shared package chain_stim_pkg.
REQ-035 The synchronizer and edge detector SHALL be sub-module edge_sync_det, with outputs rise and fall as single-cycle pulses.

Verification
REQ-036 Scenario: width=4, gap=4, count=3, with myin looped to myout through the 6-stage NOR chain -> 3 pulses of 4 cycles high / 4 low, done 24 cycles after the first myin rise, final edge_count=6.
REQ-037 Scenario: count=0 -> myin never rises, done high on the cycle after start, edge_count=0.
REQ-038 Scenario: width=1, gap=0, count=2 -> myin sequence 1,0,1,0, then done.
REQ-039 Scenario: start re-asserted while busy -> ignored, train unchanged, single done.
REQ-040 Scenario: rst_n low mid-HIGH -> myin 0 with no clock edge; after release, IDLE with all outputs 0.
REQ-041 Scenario: EDGE_W=4 with 20 myout toggles -> edge_count holds at 15.

Source files
------------

// File: rtl/chain_stim_pkg.sv
// Shared types and default widths for the chain pulse stimulus block.
package chain_stim_pkg;

  localparam int unsigned CFG_W_DEFAULT  = 8;
  localparam int unsigned EDGE_W_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/edge_sync_det.sv
// Two-flop synchronizer for an asynchronous input, followed by a history flop
// that turns level changes into single-cycle rise/fall pulses.
module edge_sync_det (
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  output logic rise,
  output logic fall
);

  logic sync1;
  logic sync2;
  logic prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= sig;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign rise = sync2 & ~prev;
  assign fall = ~sync2 & prev;

endmodule

// File: rtl/chain_pulse_stim.sv
// Drives a configurable pulse train into an external chain and counts the
// transitions that come back on its (asynchronous) output.
module chain_pulse_stim
  import chain_stim_pkg::*;
#(
  parameter int unsigned CFG_W  = CFG_W_DEFAULT,
  parameter int unsigned EDGE_W = EDGE_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CFG_W-1:0]  pulse_width,
  input  logic [CFG_W-1:0]  pulse_gap,
  input  logic [CFG_W-1:0]  pulse_count,
  output logic              myin,
  output logic              mygnd,
  input  logic              myout,
  output logic              busy,
  output logic              done,
  output logic [EDGE_W-1:0] edge_count
);

  state_t state;
  state_t state_nxt;

  logic [CFG_W-1:0] width_q;
  logic [CFG_W-1:0] gap_q;
  logic [CFG_W-1:0] cycle_cnt;
  logic [CFG_W-1:0] pulses_left;

  logic             accept_c;
  logic             cycle_last_c;
  logic             pulse_last_c;
  logic [CFG_W-1:0] gap_eff_c;

  logic myin_nxt;
  logic busy_nxt;
  logic done_nxt;

  logic rise;
  logic fall;

  assign mygnd        = 1'b0;
  assign accept_c     = (state == IDLE) && start;
  assign cycle_last_c = (cycle_cnt <= CFG_W'(1));
  assign pulse_last_c = (pulses_left <= CFG_W'(1));
  // A zero gap still produces one low cycle so pulses stay separable.
  assign gap_eff_c    = (gap_q == '0) ? CFG_W'(1) : gap_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          if ((pulse_count == '0) || (pulse_width == '0)) begin
            state_nxt = DONE;
          end else begin
            state_nxt = HIGH;
          end
        end
      end
      HIGH: begin
        if (cycle_last_c) begin
          state_nxt = LOW;
        end
      end
      LOW: begin
        if (cycle_last_c) begin
          state_nxt = pulse_last_c ? DONE : HIGH;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so myin is a clean flop output.
  always_comb begin
    myin_nxt = 1'b0;
    busy_nxt = 1'b0;
    done_nxt = 1'b0;
    case (state_nxt)
      HIGH: begin
        myin_nxt = 1'b1;
        busy_nxt = 1'b1;
      end
      LOW:     busy_nxt = 1'b1;
      DONE:    done_nxt = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      myin <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      myin <= myin_nxt;
      busy <= busy_nxt;
      done <= done_nxt;
    end
  end

  // Config latch and down-counters; counters hold at zero rather than wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      width_q     <= '0;
      gap_q       <= '0;
      cycle_cnt   <= '0;
      pulses_left <= '0;
    end else if (accept_c) begin
      width_q     <= pulse_width;
      gap_q       <= pulse_gap;
      cycle_cnt   <= pulse_width;
      pulses_left <= pulse_count;
    end else begin
      case (state)
        HIGH: begin
          if (cycle_last_c) begin
            cycle_cnt <= gap_eff_c;
          end else if (cycle_cnt != '0) begin
            cycle_cnt <= cycle_cnt - CFG_W'(1);
          end
        end
        LOW: begin
          if (cycle_last_c) begin
            if (!pulse_last_c) begin
              cycle_cnt   <= width_q;
              pulses_left <= pulses_left - CFG_W'(1);
            end
          end else if (cycle_cnt != '0) begin
            cycle_cnt <= cycle_cnt - CFG_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  edge_sync_det u_edge_sync_det (
    .clk   (clk),
    .rst_n (rst_n),
    .sig   (myout),
    .rise  (rise),
    .fall  (fall)
  );

  // Accepted start clears the count even if an edge lands in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_count <= '0;
    end else if (accept_c) begin
      edge_count <= '0;
    end else if ((rise || fall) && (edge_count != '1)) begin
      edge_count <= edge_count + EDGE_W'(1);
    end
  end

endmodule
